// File: rtl/linebuf_bank_sched_pkg.sv
// Shared constants and helpers for the scanline bank scheduler and line buffer RAM addressing.
package linebuf_pkg;

    localparam logic [0:0] SCHED_PRIME = 1'b0;
    localparam logic [0:0] SCHED_RUN   = 1'b1;

    localparam int NBANKS_DEF      = 4;
    localparam int PRIME_LINES_DEF = 2;

    // Bank index width; a single bank still needs a 1-bit index.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/linebuf_bank_sched_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   cnt <= '0;
        else if (clear)              cnt <= '0;
        else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/linebuf_bank_sched.sv
// Writer/reader bank scheduler for the multi-bank scanline buffer.
// Optional diagnostic counters enabled by defining LINEBUF_SCHED_STATS_EN.
module linebuf_bank_sched
    import linebuf_pkg::*;
#(
    parameter int NBANKS      = NBANKS_DEF,
    parameter int PRIME_LINES = PRIME_LINES_DEF,
    parameter int CNT_W       = 8,
    localparam int BANK_W     = bank_w(NBANKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_line_start,
    input  logic              src_line_end,
    input  logic              dst_vs,
    input  logic              dst_line_start,
    output logic [BANK_W-1:0] wr_bank,
    output logic              wr_gate,
    output logic [BANK_W-1:0] rd_bank,
    output logic              rd_valid,
    output logic              dup,
    output logic [BANK_W:0]   fill,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  underrun_cnt
);

    localparam int FILL_W = BANK_W + 1;
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NBANKS - 1);
    localparam logic [FILL_W-1:0] FILL_PRIM = FILL_W'(PRIME_LINES);

    logic [0:0]        state, state_n;
    logic              writing, writing_n;
    logic [BANK_W-1:0] wr_bank_n, rd_bank_n;
    logic [FILL_W-1:0] fill_n;
    logic              wr_gate_n, rd_valid_n, dup_n;
`ifdef LINEBUF_SCHED_STATS_EN
    logic              ovr_inc, und_inc;
`endif

    // Events are applied in a fixed order; each stage sees the fill left by the previous one.
    always_comb begin
        state_n    = state;
        writing_n  = writing;
        wr_bank_n  = wr_bank;
        rd_bank_n  = rd_bank;
        fill_n     = fill;
        wr_gate_n  = wr_gate;
        rd_valid_n = rd_valid;
        dup_n      = dup;
`ifdef LINEBUF_SCHED_STATS_EN
        ovr_inc    = 1'b0;
        und_inc    = 1'b0;
`endif

        if (src_line_end && writing) begin
            fill_n    = fill_n + 1'b1;
            wr_bank_n = wr_bank_n + 1'b1;
            writing_n = 1'b0;
            wr_gate_n = 1'b0;
        end

        if (dst_line_start) begin
            if (state_n == SCHED_PRIME) begin
                if (fill_n >= FILL_PRIM) begin
                    rd_bank_n  = rd_bank_n + 1'b1;
                    fill_n     = fill_n - 1'b1;
                    rd_valid_n = 1'b1;
                    state_n    = SCHED_RUN;
                end
            end else if (fill_n != '0) begin
                rd_bank_n = rd_bank_n + 1'b1;
                fill_n    = fill_n - 1'b1;
                dup_n     = 1'b0;
            end else begin
                dup_n = 1'b1;
`ifdef LINEBUF_SCHED_STATS_EN
                und_inc = 1'b1;
`endif
            end
        end

        // Frame realignment skips stale lines so latency returns to the priming depth.
        if (dst_vs && state_n == SCHED_RUN && fill_n > FILL_PRIM) begin
            rd_bank_n = rd_bank_n + BANK_W'(fill_n - FILL_PRIM);
            fill_n    = FILL_PRIM;
        end

        if (src_line_start) begin
            if (fill_n == FILL_MAX) begin
                wr_gate_n = 1'b0;
                writing_n = 1'b0;
`ifdef LINEBUF_SCHED_STATS_EN
                ovr_inc = 1'b1;
`endif
            end else begin
                wr_gate_n = 1'b1;
                writing_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SCHED_PRIME;
            writing  <= 1'b0;
            wr_bank  <= BANK_W'(1);
            rd_bank  <= '0;
            fill     <= '0;
            wr_gate  <= 1'b0;
            rd_valid <= 1'b0;
            dup      <= 1'b0;
        end else begin
            state    <= state_n;
            writing  <= writing_n;
            wr_bank  <= wr_bank_n;
            rd_bank  <= rd_bank_n;
            fill     <= fill_n;
            wr_gate  <= wr_gate_n;
            rd_valid <= rd_valid_n;
            dup      <= dup_n;
        end
    end

`ifdef LINEBUF_SCHED_STATS_EN
    sat_counter #(.W(CNT_W)) u_ovr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ovr_inc),
        .clear (1'b0),
        .cnt   (overrun_cnt)
    );

    sat_counter #(.W(CNT_W)) u_und_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (und_inc),
        .clear (1'b0),
        .cnt   (underrun_cnt)
    );
`else
    assign overrun_cnt  = '0;
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_linebuf_bank_sched.sv
// Directed scoreboard bench for linebuf_bank_sched (NBANKS=4, PRIME_LINES=2, CNT_W=8).
module tb_linebuf_bank_sched;

    typedef struct packed {
        logic [1:0] wr_bank;
        logic       wr_gate;
        logic [1:0] rd_bank;
        logic       rd_valid;
        logic       dup;
        logic [2:0] fill;
        logic [7:0] ovr;
        logic [7:0] und;
    } snap_t;

`ifdef LINEBUF_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // event bits {line_end, dst_line_start, dst_vs, src_line_start}
    localparam logic [3:0] EV_N = 4'b0000;
    localparam logic [3:0] EV_S = 4'b0001;
    localparam logic [3:0] EV_V = 4'b0010;
    localparam logic [3:0] EV_L = 4'b0100;
    localparam logic [3:0] EV_E = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       src_line_start, src_line_end, dst_vs, dst_line_start;
    logic [1:0] wr_bank, rd_bank;
    logic       wr_gate, rd_valid, dup;
    logic [2:0] fill;
    logic [7:0] overrun_cnt, underrun_cnt;

    int    tests  = 0;
    int    failed = 0;
    snap_t sb[$];

    always #5 clk = ~clk;

    linebuf_bank_sched #(.NBANKS(4), .PRIME_LINES(2), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .src_line_start (src_line_start),
        .src_line_end   (src_line_end),
        .dst_vs         (dst_vs),
        .dst_line_start (dst_line_start),
        .wr_bank        (wr_bank),
        .wr_gate        (wr_gate),
        .rd_bank        (rd_bank),
        .rd_valid       (rd_valid),
        .dup            (dup),
        .fill           (fill),
        .overrun_cnt    (overrun_cnt),
        .underrun_cnt   (underrun_cnt)
    );

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        snap_t e;
        e = sb.pop_front();
        cmp(tag, "wr_bank",  32'(wr_bank),      32'(e.wr_bank));
        cmp(tag, "wr_gate",  32'(wr_gate),      32'(e.wr_gate));
        cmp(tag, "rd_bank",  32'(rd_bank),      32'(e.rd_bank));
        cmp(tag, "rd_valid", 32'(rd_valid),     32'(e.rd_valid));
        cmp(tag, "dup",      32'(dup),          32'(e.dup));
        cmp(tag, "fill",     32'(fill),         32'(e.fill));
        cmp(tag, "ovr_cnt",  32'(overrun_cnt),  32'(e.ovr));
        cmp(tag, "und_cnt",  32'(underrun_cnt), 32'(e.und));
    endtask

    function automatic snap_t mk(input int wb, input int g, input int rb, input int v,
                                 input int d, input int f, input int o, input int u);
        snap_t s;
        s.wr_bank  = 2'(wb);
        s.wr_gate  = 1'(g);
        s.rd_bank  = 2'(rb);
        s.rd_valid = 1'(v);
        s.dup      = 1'(d);
        s.fill     = 3'(f);
        s.ovr      = STATS ? 8'(o) : 8'd0;
        s.und      = STATS ? 8'(u) : 8'd0;
        return s;
    endfunction

    // Drive one cycle of event pulses, queue the expected registered result, compare after the edge.
    task automatic step(input string tag, input logic [3:0] ev, input snap_t e);
        @(negedge clk);
        {src_line_end, dst_line_start, dst_vs, src_line_start} = ev;
        sb.push_back(e);
        @(posedge clk);
        #1;
        {src_line_end, dst_line_start, dst_vs, src_line_start} = 4'b0000;
        check_pop(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, failed + 1);
    end

    initial begin
        {src_line_end, dst_line_start, dst_vs, src_line_start} = 4'b0000;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        check_pop("reset");
        @(negedge clk);
        reset = 1'b0;

        // priming
        step("prime_s1",    EV_S,        mk(1, 1, 0, 0, 0, 0, 0, 0));
        step("prime_e1",    EV_E,        mk(2, 0, 0, 0, 0, 1, 0, 0));
        step("prime_early", EV_L | EV_V, mk(2, 0, 0, 0, 0, 1, 0, 0));
        step("prime_s2",    EV_S,        mk(2, 1, 0, 0, 0, 1, 0, 0));
        step("prime_e2",    EV_E,        mk(3, 0, 0, 0, 0, 2, 0, 0));
        step("prime_go",    EV_L,        mk(3, 0, 1, 1, 0, 1, 0, 0));
        step("vs_nochg",    EV_V,        mk(3, 0, 1, 1, 0, 1, 0, 0));
        step("rd_next",     EV_L,        mk(3, 0, 2, 1, 0, 0, 0, 0));

        // underrun and recovery
        step("underrun",    EV_L,        mk(3, 0, 2, 1, 1, 0, 0, 1));
        step("rec_s",       EV_S,        mk(3, 1, 2, 1, 1, 0, 0, 1));
        step("rec_e",       EV_E,        mk(0, 0, 2, 1, 1, 1, 0, 1));
        step("rec_l",       EV_L,        mk(0, 0, 3, 1, 0, 0, 0, 1));

        // writer outruns reader
        step("fill_s1",     EV_S,        mk(0, 1, 3, 1, 0, 0, 0, 1));
        step("fill_e1",     EV_E,        mk(1, 0, 3, 1, 0, 1, 0, 1));
        step("fill_s2",     EV_S,        mk(1, 1, 3, 1, 0, 1, 0, 1));
        step("fill_e2",     EV_E,        mk(2, 0, 3, 1, 0, 2, 0, 1));
        step("fill_s3",     EV_S,        mk(2, 1, 3, 1, 0, 2, 0, 1));
        step("fill_e3",     EV_E,        mk(3, 0, 3, 1, 0, 3, 0, 1));
        step("overrun",     EV_S,        mk(3, 0, 3, 1, 0, 3, 1, 1));
        step("ovr_end_ign", EV_E,        mk(3, 0, 3, 1, 0, 3, 1, 1));

        // frame realignment drops the stale line
        step("realign",     EV_V,        mk(3, 0, 0, 1, 0, 2, 1, 1));

        // simultaneous write completion and read
        step("sim_l",       EV_L,        mk(3, 0, 1, 1, 0, 1, 1, 1));
        step("sim_s",       EV_S,        mk(3, 1, 1, 1, 0, 1, 1, 1));
        step("sim_el",      EV_E | EV_L, mk(0, 0, 2, 1, 0, 1, 1, 1));

        // restart of a partial line does not advance the bank
        step("abort_s1",    EV_S,        mk(0, 1, 2, 1, 0, 1, 1, 1));
        step("abort_s2",    EV_S,        mk(0, 1, 2, 1, 0, 1, 1, 1));
        step("abort_e",     EV_E,        mk(1, 0, 2, 1, 0, 2, 1, 1));

        // asynchronous reset while a line is being written
        step("mid_s",       EV_S,        mk(1, 1, 2, 1, 0, 2, 1, 1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        check_pop("async_rst");
        @(posedge clk);
        #1;
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        check_pop("rst_held");
        @(negedge clk);
        reset = 1'b0;
        step("post_e_ign",  EV_E,        mk(1, 0, 0, 0, 0, 0, 0, 0));
        step("post_s",      EV_S,        mk(1, 1, 0, 0, 0, 0, 0, 0));
        step("post_e",      EV_E,        mk(2, 0, 0, 0, 0, 1, 0, 0));
        step("post_s2",     EV_S,        mk(2, 1, 0, 0, 0, 1, 0, 0));
        step("post_e2",     EV_E,        mk(3, 0, 0, 0, 0, 2, 0, 0));
        step("post_go",     EV_L,        mk(3, 0, 1, 1, 0, 1, 0, 0));
        step("post_drain",  EV_L,        mk(3, 0, 2, 1, 0, 0, 0, 0));

        // underrun counter saturation
        for (int i = 1; i <= 260; i++) begin
            step("und_sat", EV_L, mk(3, 0, 2, 1, 1, 0, 0, (i > 255) ? 255 : i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/linebuf_bank_sched.md
Name: linebuf_bank_sched

Overview:
- Schedules a multi-bank scanline buffer shared by the source pixel writer and the display reader in the video output path.
- Decides which bank the writer fills and which bank the display reads.
- Gates writes when the buffer is full and repeats the previous line when it is empty.
- Realigns reader to writer once per display frame. All events arrive as single-cycle pulses already synchronised to clk.

Parameters:
- NBANKS, 4, number of line banks; power of two, 2..8; BANK_W = clog2(NBANKS) is a derived localparam.
- PRIME_LINES, 2, completed lines required before display starts, and the target fill after realignment; 1..NBANKS-1.
- CNT_W, 8, width of the saturating diagnostic counters.

Ports:
- clk  in  1  display pixel clock
- reset  in  1  asynchronous, active-high
- src_line_start  in  1  pulse: writer begins a line
- src_line_end  in  1  pulse: writer finished a line
- dst_vs  in  1  pulse: display frame start
- dst_line_start  in  1  pulse: display begins reading a line
- wr_bank  out  BANK_W  bank the writer targets
- wr_gate  out  1  writes for the current source line are permitted
- rd_bank  out  BANK_W  bank the display reads
- rd_valid  out  1  rd_bank holds a displayable line; 0 means output black
- dup  out  1  current display line is a repeat
- fill  out  BANK_W+1  completed, undisplayed lines
- overrun_cnt  out  CNT_W  lines dropped (saturating)
- underrun_cnt  out  CNT_W  lines repeated (saturating)

Behaviour:
- Reset values: rd_bank=0, wr_bank=1, fill=0, wr_gate=0, rd_valid=0, dup=0, counters=0, state=PRIME, internal writing flag=0.
- Invariant: wr_bank == (rd_bank+fill+1) mod NBANKS whenever writing=0.
- All outputs are registered and update on the clk edge after the event pulse (latency 1).
- Per-cycle event order: line_end, then dst_line_start, then dst_vs, then src_line_start. Each stage sees the fill value produced by the previous stage.
- src_line_end:
  - If writing=1: fill+1, wr_bank+1, writing=0, wr_gate=0.
  - If writing=0: ignored.
- src_line_start:
  - If fill==NBANKS-1 (overrun): wr_gate=0, writing=0, overrun_cnt+1. The matching line_end is ignored.
  - Otherwise: wr_gate=1, writing=1.
  - A start while writing=1 aborts the partial line; wr_bank does not advance.
- State PRIME:
  - rd_valid=0, dup=0.
  - On dst_line_start with fill>=PRIME_LINES: rd_bank+1, fill-1, rd_valid=1, state=RUN.
- State RUN, on dst_line_start:
  - fill>0: rd_bank+1, fill-1, dup=0.
  - fill==0: rd_bank held, dup=1, underrun_cnt+1.
  - rd_valid stays 1.
- dst_vs in RUN:
  - fill>PRIME_LINES: rd_bank += fill-PRIME_LINES, fill=PRIME_LINES (drops stale lines). Not counted as overrun.
  - Otherwise: no change.
- dst_vs in PRIME: no effect.
- Counters saturate at 2^CNT_W-1.
- Reset mid-line: all state returns to reset values immediately (async). The writer's partial line is discarded.
- Bank arithmetic wraps mod NBANKS. fill never exceeds NBANKS-1.

Optional Feature:
- LINEBUF_SCHED_STATS_EN
  - Defined: overrun_cnt and underrun_cnt are implemented as specified.
  - Undefined: both ports are driven constant 0 and the counter registers are absent. Scheduling behaviour is identical.

Decomposition:
- Package linebuf_pkg holds:
  - state encoding constants (SCHED_PRIME=0, SCHED_RUN=1)
  - NBANKS/PRIME_LINES defaults
  - a bank-width helper function shared with the line buffer RAM addressing.
- One sub-module, sat_counter (width parameter, inc, clear), instantiated twice under the macro.

Test Plan:
- Reset then 2 src line start/end pairs, then dst_line_start -> fill 0→1→2; rd_bank=1, fill=1, rd_valid=1, RUN, wr_bank=3.
- In RUN with fill=0, dst_line_start -> dup=1, rd_bank unchanged, underrun_cnt=1; next completed line plus dst_line_start -> dup=0.
- Writer outruns reader until fill=3 (NBANKS=4), then src_line_start -> wr_gate=0, overrun_cnt=1; following line_end leaves fill=3 and wr_bank unchanged.
- fill=3 in RUN, dst_vs -> rd_bank advances by 1, fill=2.
- src_line_end and dst_line_start in the same cycle, fill=1 -> fill stays 1, both rd_bank and wr_bank advance by 1.
- Assert reset mid-line with writing=1 -> all outputs at reset values the next sampled cycle. With the macro undefined, counters read 0 throughout the overrun test.
